// File: rtl/sub_pkg.sv
// Shared types and helpers for the digit-serial subtractor.
package sub_pkg;

  // Control states of the serial subtractor.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sub_state_e;

  // Width of a counter that indexes ndig digits. A single-digit
  // configuration still gets a one-bit counter so the vector stays legal.
  function automatic int cnt_width(input int ndig);
    return (ndig > 1) ? $clog2(ndig) : 1;
  endfunction

endpackage : sub_pkg

// File: rtl/sub_digit.sv
// Combinational DIGIT_W-bit borrow-ripple subtractor: d = x - y - c_in,
// with c_out set when the digit had to borrow from the next one up.
module sub_digit #(
  parameter int DIGIT_W = 4
) (
  input  logic [DIGIT_W-1:0] x,
  input  logic [DIGIT_W-1:0] y,
  input  logic               c_in,
  output logic [DIGIT_W-1:0] d,
  output logic               c_out
);

  // Ripple the borrow through one full-subtractor cell per bit.
  always_comb begin
    logic c;
    // NOTE: combinational blocks assign every output a default first and use
    // blocking '=' so the ripple variable updates in order and no latch forms.
    d = '0;
    c = c_in;
    for (int i = 0; i < DIGIT_W; i++) begin
      d[i] = x[i] ^ y[i] ^ c;
      c    = (~x[i] & y[i]) | (~x[i] & c) | (y[i] & c);
    end
    c_out = c;
  end

endmodule : sub_digit

// File: rtl/serial_subtractor_32.sv
// Digit-serial two's-complement subtractor: diff = a - b - bin over WIDTH
// bits, DIGIT_W bits per cycle, LSB digit first, behind valid/ready.
// Optional macro SUB_OVERFLOW_EN adds the signed-overflow output ovf.
module serial_subtractor_32
  import sub_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int DIGIT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef SUB_OVERFLOW_EN
  ,
  output logic             ovf
`endif
);

  localparam int NDIG  = WIDTH / DIGIT_W;
  localparam int CNT_W = cnt_width(NDIG);
  localparam logic [CNT_W-1:0] LAST_DIG = CNT_W'(NDIG - 1);

  if ((WIDTH % DIGIT_W) != 0) begin : g_bad_cfg
    $error("serial_subtractor_32: DIGIT_W (%0d) must divide WIDTH (%0d)",
           DIGIT_W, WIDTH);
  end

  sub_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             borrow_q, borrow_d;

  logic [DIGIT_W-1:0] dig_diff;
  logic               dig_borrow;
  logic [WIDTH-1:0]   diff_shift;

  // One digit slice, fed from the low end of the operand shift registers.
  sub_digit #(
    .DIGIT_W (DIGIT_W)
  ) u_digit (
    .x     (a_q[DIGIT_W-1:0]),
    .y     (b_q[DIGIT_W-1:0]),
    .c_in  (borrow_q),
    .d     (dig_diff),
    .c_out (dig_borrow)
  );

  // New digit enters diff from the MSB side, so after NDIG shifts the first
  // (least significant) digit has travelled down to bit 0.
  if (NDIG == 1) begin : g_diff_single
    assign diff_shift = dig_diff;
  end else begin : g_diff_multi
    assign diff_shift = {dig_diff, diff_q[WIDTH-1:DIGIT_W]};
  end

  // Next-state and datapath update for the IDLE/RUN/DONE sequence.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d      = a;
          b_d      = b;
          borrow_d = bin;
          cnt_d    = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        a_d      = a_q >> DIGIT_W;
        b_d      = b_q >> DIGIT_W;
        diff_d   = diff_shift;
        borrow_d = dig_borrow;
        if (cnt_q == LAST_DIG) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control state and the externally visible result registers.
  always_ff @(posedge clk) begin
    // NOTE: sequential state is written only with non-blocking '<=' so every
    // flop samples values from before the edge, independent of block order.
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
    end
  end

  // Operand shift registers and latched sign bits.
  always_ff @(posedge clk) begin
    // NOTE: these carry no reset: they are always loaded on accept before
    // being read, and never reach an output outside DONE.
    a_q <= a_d;
    b_q <= b_d;
  end

`ifdef SUB_OVERFLOW_EN
  logic a_msb_q;
  logic b_msb_q;

  // Capture operand signs on accept; the shift registers lose them.
  always_ff @(posedge clk) begin
    if (state_q == IDLE && in_valid) begin
      a_msb_q <= a[WIDTH-1];
      b_msb_q <= b[WIDTH-1];
    end
  end

  assign ovf = (state_q == DONE) && (a_msb_q != b_msb_q) &&
               (diff_q[WIDTH-1] != a_msb_q);
`endif

  // Handshake decode from registered state; the synchronous reset is the
  // only input allowed to hold in_ready low, so no accept races a reset.
  assign in_ready  = (state_q == IDLE) && !rst;
  assign out_valid = (state_q == DONE);
  assign diff      = diff_q;
  assign bout      = borrow_q;

endmodule : serial_subtractor_32

// File: doc/serial_subtractor_32.md
# serial_subtractor_32

Multi-cycle, digit-serial two's-complement subtractor. It computes `diff = a - b - bin` over WIDTH bits, DIGIT_W bits per cycle, LSB digit first, and produces the final borrow-out. It is the inverse-direction companion to the 32-bit ripple full-adder benchmark. It sits behind a valid/ready handshake so it can be dropped into datapaths that trade area for latency.

## Interface
Parameters:
- `WIDTH`, 32: operand and result width.
- `DIGIT_W`, 4: bits processed per cycle. Must divide WIDTH; elaboration error otherwise.

Ports:
- `clk`, in, 1: sole clock; all logic on the rising edge.
- `rst`, in, 1: reset, synchronous, active-high.
- `in_valid`, in, 1: operands valid.
- `in_ready`, out, 1: block can accept operands.
- `a`, in, WIDTH: minuend.
- `b`, in, WIDTH: subtrahend.
- `bin`, in, 1: borrow-in.
- `out_valid`, out, 1: result valid.
- `out_ready`, in, 1: consumer accepts result.
- `diff`, out, WIDTH: `(a - b - bin) mod 2^WIDTH`.
- `bout`, out, 1: borrow-out; 1 iff unsigned `a < b + bin`.
- `ovf`, out, 1: signed overflow. Present only with SUB_OVERFLOW_EN.

## Operation
- `NDIG = WIDTH/DIGIT_W`. FSM states: IDLE, RUN, DONE.
- **IDLE**
  - `in_ready = 1`.
  - On `in_valid && in_ready`: latch `a`, `b`, and `bin` into shift registers and the borrow flop; clear digit counter; go to RUN.
- **RUN**
  - Each cycle, subtract the low DIGIT_W bits of the a/b shift registers with the current borrow.
  - Shift the result digit into the diff register from the MSB side; store the new borrow; increment the counter.
  - After the NDIG-th digit, go to DONE.
  - `in_valid` is ignored.
- **DONE**
  - `out_valid = 1`; `diff`, `bout`, and `ovf` are held stable.
  - On `out_ready`, go to IDLE.
  - `in_ready = 0`, so a result and a new accept never coincide.
- Per-bit cell:
  - `d = x ^ y ^ c`
  - `c' = (!x & y) | (!x & c) | (y & c)`
- `ovf = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB])`, using the latched `a` and `b` MSBs. It is computed in DONE; `bin` is included in diff.
- **Reset** (any state, including mid-RUN):
  - Next edge forces IDLE; the operation in flight is discarded.
  - Output values: `out_valid = 0`, `diff = 0`, `bout = 0`, `ovf = 0`.
  - `in_ready` is 0 while `rst` is high and 1 in the first cycle after `rst` is released.
- The counter wraps only by returning to IDLE; it never exceeds `NDIG-1`.

## Timing
- `in_ready` and `out_valid` are decoded from registered state only; no combinational input-to-output paths.
- Acceptance edge is edge 0. RUN occupies edges 1..NDIG. `out_valid` rises after edge NDIG (8 cycles for defaults).
- `DIGIT_W = WIDTH` gives 1 RUN cycle; `DIGIT_W = 1` gives 32.
- Throughput: one operation per `NDIG + 2` cycles minimum. DONE lasts at least 1 cycle, and IDLE lasts at least 1 cycle for the accept.
- `out_ready` held low stalls DONE indefinitely with outputs frozen.

## Configuration
- `SUB_OVERFLOW_EN` defined: `ovf` port exists, along with the two latched MSB flops and the overflow logic.
- Not defined: `ovf` port and logic are absent. All other behaviour and timing are identical.

## Structure
- Package `sub_pkg`:
  - state enum `sub_state_e` (IDLE, RUN, DONE);
  - function computing the counter width `$clog2(NDIG)`, minimum 1.
- Sub-module `sub_digit`: combinational DIGIT_W-bit borrow-ripple subtractor built from the per-bit cell.
  - Ports: `x[DIGIT_W]`, `y[DIGIT_W]`, `c_in` → `d[DIGIT_W]`, `c_out`.
  - Instantiated once; the top holds the FSM, counter, and shift registers.

## Test plan
Defaults are `WIDTH = 32`, `DIGIT_W = 4`.
- `a=5, b=3, bin=0` → `diff=0x00000002`, `bout=0`; `out_valid` rises exactly 8 cycles after the accept edge.
- `a=0, b=1, bin=0` → `diff=0xFFFFFFFF`, `bout=1`.
- `a=0x80000000, b=1, bin=0` with SUB_OVERFLOW_EN → `diff=0x7FFFFFFF`, `bout=0`, `ovf=1`. With `a=10, b=3` → `ovf=0`.
- Backpressure: hold `out_ready=0` for 5 cycles and pulse `in_valid` during DONE → `diff` and `out_valid` stable, `in_ready=0`, pulse ignored. On release, `in_ready=1` next cycle.
- Assert `rst` on the 3rd RUN cycle → next cycle `out_valid=0`, `diff=0`. Then `a=10, b=10, bin=1` → `diff=0xFFFFFFFF`, `bout=1`.
- Rebuild with `DIGIT_W=1` and `DIGIT_W=32`; run 10k random `a`, `b`, `bin` against a `{bout, diff}` reference → exact match; latency 32 and 1 respectively.
